// File: rtl/fejkon_pcie_pkg.sv
// Shared TLP constants, completion status codes and completer FSM states for
// the fejkon PCIe completion transmitter.
package fejkon_pcie_pkg;

    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;

    typedef enum logic [2:0] {
        CPL_SC = 3'b000,
        CPL_UR = 3'b001,
        CPL_CA = 3'b100
    } cpl_status_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_TX      = 2'd3
    } cpl_state_e;

    // Header DW0 of a single-dword CplD, or of a data-less Cpl when nodata is set.
    function automatic logic [31:0] cpl_dw0(input logic nodata, input logic [2:0] tc,
                                            input logic [1:0] attr);
        logic [2:0] fmt;
        logic [9:0] len;
        fmt = nodata ? FMT_3DW_NODATA : FMT_3DW_DATA;
        len = nodata ? 10'd0 : 10'd1;
        return {fmt, TYPE_CPL, 1'b0, tc, 4'b0000, 2'b00, attr, 2'b00, len};
    endfunction

endpackage

// File: rtl/fejkon_pcie_cpl_bytecount.sv
// Derives the completion byte count and the lower-address byte offset from a
// read request's first-dword byte enables.
module fejkon_pcie_cpl_bytecount (
    input  logic [3:0]  first_be,
    output logic [11:0] byte_count,
    output logic [1:0]  addr_offset
);

    // Byte count spans from the lowest to the highest enabled byte.
    always_comb begin
        byte_count = 12'd1;
        casez (first_be)
            4'b1??1:                   byte_count = 12'd4;
            4'b01?1, 4'b1?10:          byte_count = 12'd3;
            4'b0011, 4'b0110, 4'b1100: byte_count = 12'd2;
            default:                   byte_count = 12'd1;
        endcase
    end

    // Offset of the lowest enabled byte; an empty mask reports offset zero.
    always_comb begin
        addr_offset = 2'd0;
        casez (first_be)
            4'b???1: addr_offset = 2'd0;
            4'b??10: addr_offset = 2'd1;
            4'b?100: addr_offset = 2'd2;
            4'b1000: addr_offset = 2'd3;
            default: addr_offset = 2'd0;
        endcase
    end

endmodule

// File: rtl/fejkon_pcie_cpl_tx.sv
// Serves one memory-read descriptor at a time from BAR0 and returns it as a
// single-beat CplD. Define FEJKON_PCIE_CPL_TIMEOUT_EN for a Completer-Abort timeout.
module fejkon_pcie_cpl_tx
    import fejkon_pcie_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] COMPLETER_ID   = 16'h0000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    input  logic [3:0]   req_first_be,
    input  logic [15:0]  req_requester_id,
    input  logic [7:0]   req_tag,
    input  logic [2:0]   req_tc,
    input  logic [1:0]   req_attr,
    output logic [31:0]  bar0_mm_address,
    output logic         bar0_mm_read,
    input  logic         bar0_mm_waitrequest,
    input  logic [31:0]  bar0_mm_readdata,
    input  logic         bar0_mm_readdatavalid,
    output logic [255:0] tx_st_data,
    output logic         tx_st_valid,
    input  logic         tx_st_ready,
    output logic         tx_st_startofpacket,
    output logic         tx_st_endofpacket,
    output logic         tx_st_error,
    output logic [1:0]   tx_st_empty
);

    cpl_state_e    state_r;
    cpl_state_e    state_s;
    cpl_status_e   status_s;
    logic          req_ready_r;
    logic          rd_r;
    logic          valid_r;
    logic [255:0]  data_r;
    logic [1:0]    empty_r;
    logic [31:2]   addr_r;
    logic [3:0]    be_r;
    logic [15:0]   rid_r;
    logic [7:0]    tag_r;
    logic [2:0]    tc_r;
    logic [1:0]    attr_r;
    logic          accept_s;
    logic          capture_s;
    logic          timeout_s;
    logic          ca_s;
    logic [11:0]   bc_s;
    logic [1:0]    off_s;
    logic [31:0]   dw0_s;
    logic [31:0]   dw1_s;
    logic [31:0]   dw2_s;
    logic [255:0]  frame_s;
    logic [1:0]    empty_s;
    logic          unused_s;

    assign accept_s = req_valid && req_ready_r;
    assign unused_s = ^req_addr[1:0];

    fejkon_pcie_cpl_bytecount u_bytecount (
        .first_be    (be_r),
        .byte_count  (bc_s),
        .addr_offset (off_s)
    );

`ifdef FEJKON_PCIE_CPL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_r;

    // Cycles spent on the current BAR0 read; idle states hold it at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_RD_REQ || state_r == ST_RD_WAIT) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign timeout_s = (state_r == ST_RD_REQ || state_r == ST_RD_WAIT) &&
                       (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_to_s;
    assign timeout_s   = 1'b0;
    assign unused_to_s = (TIMEOUT_CYCLES != 32'sd0);
`endif

    // Next-state decode; read data only counts once the read has been accepted.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        ca_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_RD_REQ;
                else          state_s = ST_IDLE;
            end
            ST_RD_REQ: begin
                if (!bar0_mm_waitrequest && bar0_mm_readdatavalid) begin
                    capture_s = 1'b1;
                    state_s   = ST_TX;
                end else if (timeout_s) begin
                    ca_s    = 1'b1;
                    state_s = ST_TX;
                end else if (!bar0_mm_waitrequest) begin
                    state_s = ST_RD_WAIT;
                end else begin
                    state_s = ST_RD_REQ;
                end
            end
            ST_RD_WAIT: begin
                if (bar0_mm_readdatavalid) begin
                    capture_s = 1'b1;
                    state_s   = ST_TX;
                end else if (timeout_s) begin
                    ca_s    = 1'b1;
                    state_s = ST_TX;
                end else begin
                    state_s = ST_RD_WAIT;
                end
            end
            ST_TX: begin
                if (tx_st_ready) state_s = ST_IDLE;
                else             state_s = ST_TX;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Completion beat: 3DW header, then payload in the dword matching addr[2].
    always_comb begin
        status_s = ca_s ? CPL_CA : CPL_SC;
        dw0_s    = cpl_dw0(ca_s, tc_r, attr_r);
        dw1_s    = {COMPLETER_ID, status_s, 1'b0, bc_s};
        dw2_s    = {rid_r, tag_r, 1'b0, addr_r[6:2], off_s};
        frame_s  = 256'd0;
        frame_s[95:0] = {dw2_s, dw1_s, dw0_s};
        empty_s  = 2'd2;
        if (ca_s) begin
            empty_s = 2'd2;
        end else if (addr_r[2]) begin
            frame_s[127:96] = bar0_mm_readdata;
            empty_s         = 2'd2;
        end else begin
            frame_s[159:128] = bar0_mm_readdata;
            empty_s          = 2'd1;
        end
    end

    // State plus handshake outputs, all registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
            rd_r        <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            req_ready_r <= (state_s == ST_IDLE);
            rd_r        <= (state_s == ST_RD_REQ);
            valid_r     <= (state_s == ST_TX);
        end
    end

    // Descriptor fields are captured on acceptance and held for the whole request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r <= 30'd0;
            be_r   <= 4'd0;
            rid_r  <= 16'd0;
            tag_r  <= 8'd0;
            tc_r   <= 3'd0;
            attr_r <= 2'd0;
        end else if (accept_s) begin
            addr_r <= req_addr[31:2];
            be_r   <= req_first_be;
            rid_r  <= req_requester_id;
            tag_r  <= req_tag;
            tc_r   <= req_tc;
            attr_r <= req_attr;
        end
    end

    // Beat is frozen on entry to TX and zeroed whenever no beat is offered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r  <= 256'd0;
            empty_r <= 2'd0;
        end else if (state_s == ST_TX && state_r != ST_TX) begin
            data_r  <= frame_s;
            empty_r <= empty_s;
        end else if (state_s != ST_TX) begin
            data_r  <= 256'd0;
            empty_r <= 2'd0;
        end
    end

    assign req_ready           = req_ready_r;
    assign bar0_mm_read        = rd_r;
    assign bar0_mm_address     = {addr_r, 2'b00};
    assign tx_st_data          = data_r;
    assign tx_st_valid         = valid_r;
    assign tx_st_startofpacket = valid_r;
    assign tx_st_endofpacket   = valid_r;
    assign tx_st_error         = 1'b0;
    assign tx_st_empty         = empty_r;

endmodule

// File: tb/tb_fejkon_pcie_cpl_tx.sv
// Directed plus randomized bench for fejkon_pcie_cpl_tx against a reference
// completion model built from the TLP field rules.
module tb_fejkon_pcie_cpl_tx;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = 32'd0;
    logic [3:0]   req_first_be = 4'd0;
    logic [15:0]  req_requester_id = 16'd0;
    logic [7:0]   req_tag = 8'd0;
    logic [2:0]   req_tc = 3'd0;
    logic [1:0]   req_attr = 2'd0;
    logic [31:0]  bar0_mm_address;
    logic         bar0_mm_read;
    logic         bar0_mm_waitrequest = 1'b1;
    logic [31:0]  bar0_mm_readdata = 32'd0;
    logic         bar0_mm_readdatavalid = 1'b0;
    logic [255:0] tx_st_data;
    logic         tx_st_valid;
    logic         tx_st_ready = 1'b0;
    logic         tx_st_startofpacket;
    logic         tx_st_endofpacket;
    logic         tx_st_error;
    logic [1:0]   tx_st_empty;

    int total = 0;
    int bad = 0;
    int cpl_cnt = 0;
    int exp_cpl = 0;
    logic [255:0] last_frame;
    logic [1:0]   last_empty;

    fejkon_pcie_cpl_tx #(.TIMEOUT_CYCLES(16), .COMPLETER_ID(16'h0000)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_addr              (req_addr),
        .req_first_be          (req_first_be),
        .req_requester_id      (req_requester_id),
        .req_tag               (req_tag),
        .req_tc                (req_tc),
        .req_attr              (req_attr),
        .bar0_mm_address       (bar0_mm_address),
        .bar0_mm_read          (bar0_mm_read),
        .bar0_mm_waitrequest   (bar0_mm_waitrequest),
        .bar0_mm_readdata      (bar0_mm_readdata),
        .bar0_mm_readdatavalid (bar0_mm_readdatavalid),
        .tx_st_data            (tx_st_data),
        .tx_st_valid           (tx_st_valid),
        .tx_st_ready           (tx_st_ready),
        .tx_st_startofpacket   (tx_st_startofpacket),
        .tx_st_endofpacket     (tx_st_endofpacket),
        .tx_st_error           (tx_st_error),
        .tx_st_empty           (tx_st_empty)
    );

    always #5 clk = ~clk;

    // Completed handshakes on the TX stream.
    always @(posedge clk) begin
        if (reset_n && tx_st_valid && tx_st_ready) cpl_cnt <= cpl_cnt + 1;
    end

    // Byte count spans the lowest to highest enabled byte; empty mask counts as one.
    function automatic logic [11:0] m_bc(input logic [3:0] be);
        int lo = -1;
        int hi = -1;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (lo < 0) return 12'd1;
        return 12'(hi - lo + 1);
    endfunction

    function automatic logic [1:0] m_lo(input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic logic [255:0] m_frame(input logic [31:0] a, input logic [3:0] be,
                                             input logic [15:0] rid, input logic [7:0] tag,
                                             input logic [2:0] tc, input logic [1:0] attr,
                                             input logic [31:0] rd, input logic ca);
        logic [255:0] f;
        logic [31:0]  dw0;
        logic [31:0]  dw1;
        logic [31:0]  dw2;
        f   = 256'd0;
        dw0 = (ca ? 32'h0A00_0000 : 32'h4A00_0001) | ({29'd0, tc} << 20) | ({30'd0, attr} << 12);
        dw1 = {16'h0000, (ca ? 3'b100 : 3'b000), 1'b0, m_bc(be)};
        dw2 = {rid, tag, 1'b0, a[6:2], m_lo(be)};
        f[31:0]  = dw0;
        f[63:32] = dw1;
        f[95:64] = dw2;
        if (!ca) begin
            if (a[2]) f[127:96] = rd;
            else      f[159:128] = rd;
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] be, input logic [15:0] rid,
                         input logic [7:0] tag, input logic [2:0] tc, input logic [1:0] attr);
        chk("idle_ready", {319'd0, req_ready}, {319'd0, 1'b1});
        req_valid = 1'b1; req_addr = a; req_first_be = be;
        req_requester_id = rid; req_tag = tag; req_tc = tc; req_attr = attr;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_first_be = 4'($urandom);
        req_requester_id = 16'($urandom); req_tag = 8'($urandom);
        chk("busy_ready", {319'd0, req_ready}, 320'd0);
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [3:0] be, input logic [15:0] rid,
                           input logic [7:0] tag, input logic [2:0] tc, input logic [1:0] attr,
                           input logic [31:0] rd, input int wr_n, input int rdv_lat,
                           input int rdy_n);
        logic [255:0] ef;
        logic [1:0]   ee;
        ef = m_frame(a, be, rid, tag, tc, attr, rd, 1'b0);
        ee = a[2] ? 2'd2 : 2'd1;
        issue(a, be, rid, tag, tc, attr);
        bar0_mm_waitrequest = 1'b1;
        for (int i = 0; i < wr_n; i++) begin
            chk("rd_hold", {287'd0, bar0_mm_read, bar0_mm_address}, {287'd0, 1'b1, a[31:2], 2'b00});
            @(negedge clk);
        end
        chk("rd_accept", {287'd0, bar0_mm_read, bar0_mm_address}, {287'd0, 1'b1, a[31:2], 2'b00});
        bar0_mm_waitrequest = 1'b0;
        if (rdv_lat == 0) begin
            bar0_mm_readdatavalid = 1'b1; bar0_mm_readdata = rd;
        end
        @(negedge clk);
        bar0_mm_waitrequest = 1'b1;
        if (rdv_lat != 0) begin
            for (int i = 1; i < rdv_lat; i++) begin
                chk("rd_wait", {318'd0, bar0_mm_read, tx_st_valid}, 320'd0);
                @(negedge clk);
            end
            chk("rd_wait", {318'd0, bar0_mm_read, tx_st_valid}, 320'd0);
            bar0_mm_readdatavalid = 1'b1; bar0_mm_readdata = rd;
            @(negedge clk);
        end
        bar0_mm_readdatavalid = 1'b0; bar0_mm_readdata = $urandom;
        last_frame = tx_st_data;
        last_empty = tx_st_empty;
        chk("tx_ctl", {314'd0, tx_st_valid, tx_st_startofpacket, tx_st_endofpacket, tx_st_error, tx_st_empty},
            {314'd0, 1'b1, 1'b1, 1'b1, 1'b0, ee});
        chk("tx_data", {64'd0, tx_st_data}, {64'd0, ef});
        for (int i = 0; i < rdy_n; i++) begin
            @(negedge clk);
            chk("stall", {62'd0, tx_st_valid, req_ready, tx_st_data}, {62'd0, 1'b1, 1'b0, ef});
        end
        tx_st_ready = 1'b1;
        @(negedge clk);
        tx_st_ready = 1'b0;
        exp_cpl++;
        chk("post_hs", {318'd0, tx_st_valid, req_ready}, {318'd0, 1'b0, 1'b1});
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_outs", {24'd0, req_ready, bar0_mm_read, bar0_mm_address, tx_st_valid,
            tx_st_startofpacket, tx_st_endofpacket, tx_st_error, tx_st_empty, tx_st_data}, 320'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", {319'd0, req_ready}, {319'd0, 1'b1});

        // Aligned-high dword: payload in dword 3.
        run_txn(32'h0000_0014, 4'hF, 16'h0100, 8'h2A, 3'd0, 2'd0, 32'hDEAD_BEEF, 0, 1, 0);
        chk("dw_hi_frame", {192'd0, last_frame[127:0]},
            {192'd0, 128'hDEADBEEF_01002A14_00000004_4A000001});
        chk("dw_hi_empty", {318'd0, last_empty}, {318'd0, 2'd2});

        // Aligned-low dword, partial enables: dword 3 zero, payload in dword 4.
        run_txn(32'h0000_0010, 4'b0110, 16'h1234, 8'h55, 3'd3, 2'd2, 32'hCAFE_F00D, 1, 0, 1);
        chk("dw_lo_frame", {64'd0, last_frame},
            {96'd0, 160'hCAFEF00D_00000000_12345511_00000002_4A302001});
        chk("dw_lo_empty", {318'd0, last_empty}, {318'd0, 2'd1});

        // Slow slave, then a long TX backpressure.
        run_txn(32'h8000_0104, 4'b0001, 16'hBEEF, 8'h01, 3'd7, 2'd3, 32'h1357_9BDF, 5, 3, 0);
        run_txn(32'h0000_0FF8, 4'b1000, 16'h00A5, 8'hFF, 3'd1, 2'd1, 32'h2468_ACE0, 2, 2, 10);
        repeat (2) @(negedge clk);
        chk("one_cpl_each", {288'd0, 32'(cpl_cnt)}, {288'd0, 32'(exp_cpl)});

        // Stray read data while idle is ignored.
        bar0_mm_readdatavalid = 1'b1; bar0_mm_readdata = 32'h5A5A_5A5A;
        repeat (2) @(negedge clk);
        bar0_mm_readdatavalid = 1'b0;
        @(negedge clk);
        chk("stray_rdv", {318'd0, tx_st_valid, req_ready}, {318'd0, 1'b0, 1'b1});

        // Reset while waiting for read data discards the request.
        issue(32'h0000_0020, 4'hF, 16'h7777, 8'h10, 3'd0, 2'd0);
        bar0_mm_waitrequest = 1'b0;
        @(negedge clk);
        bar0_mm_waitrequest = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_outs", {24'd0, req_ready, bar0_mm_read, bar0_mm_address, tx_st_valid,
            tx_st_startofpacket, tx_st_endofpacket, tx_st_error, tx_st_empty, tx_st_data}, 320'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bar0_mm_readdatavalid = 1'b1; bar0_mm_readdata = 32'h0BAD_0BAD;
        @(negedge clk);
        bar0_mm_readdatavalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_quiet", {318'd0, tx_st_valid, req_ready}, {318'd0, 1'b0, 1'b1});
            @(negedge clk);
        end

        // Randomized descriptors and handshake timing.
        for (int k = 0; k < 25; k++) begin
            run_txn($urandom, 4'($urandom), 16'($urandom), 8'($urandom), 3'($urandom),
                    2'($urandom), $urandom, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

`ifdef FEJKON_PCIE_CPL_TIMEOUT_EN
        // Silent slave: Completer Abort after the timeout, late data ignored.
        issue(32'h0000_0014, 4'hF, 16'h0100, 8'h2A, 3'd0, 2'd0);
        bar0_mm_waitrequest = 1'b0;
        n = 0;
        while (!tx_st_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        bar0_mm_waitrequest = 1'b1;
        chk("to_latency", {288'd0, 32'(n)}, {288'd0, 32'd16});
        chk("to_dw0", {288'd0, tx_st_data[31:0]}, {288'd0, 32'h0A00_0000});
        chk("to_status", {317'd0, tx_st_data[47:45]}, {317'd0, 3'b100});
        chk("to_frame", {64'd0, tx_st_data},
            {64'd0, m_frame(32'h0000_0014, 4'hF, 16'h0100, 8'h2A, 3'd0, 2'd0, 32'd0, 1'b1)});
        chk("to_empty", {318'd0, tx_st_empty}, {318'd0, 2'd2});
        tx_st_ready = 1'b1;
        @(negedge clk);
        tx_st_ready = 1'b0;
        exp_cpl++;
        bar0_mm_readdatavalid = 1'b1; bar0_mm_readdata = 32'hFEED_FACE;
        @(negedge clk);
        bar0_mm_readdatavalid = 1'b0;
        @(negedge clk);
        chk("to_late_rdv", {318'd0, tx_st_valid, req_ready}, {318'd0, 1'b0, 1'b1});
`else
        n = 0;
`endif

        repeat (3) @(negedge clk);
        chk("cpl_count", {288'd0, 32'(cpl_cnt)}, {288'd0, 32'(exp_cpl)});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fejkon_pcie_cpl_tx.md
FEJKON_PCIE_CPL_TX -- requirements
Module: fejkon_pcie_cpl_tx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum cycles awaited for bar0 readdatavalid (used only with the timeout feature).
REQ-002 SHALL have parameter COMPLETER_ID, default 16'h0000, meaning the value placed in the Completer ID field.
REQ-003 SHALL have clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have req_valid/req_ready, input/output, 1 each; these form the read-request descriptor handshake.
REQ-006 SHALL have req_addr input 32 (byte address), req_first_be input 4, req_requester_id input 16, req_tag input 8, req_tc input 3, req_attr input 2.
REQ-007 SHALL have bar0_mm_address output 32, bar0_mm_read output 1, bar0_mm_waitrequest input 1, bar0_mm_readdata input 32, bar0_mm_readdatavalid input 1.
REQ-008 SHALL have tx_st_data output 256, tx_st_valid output 1, tx_st_ready input 1, tx_st_startofpacket output 1, tx_st_endofpacket output 1, tx_st_error output 1, tx_st_empty output 2 (empty qwords).

Function
REQ-009 SHALL implement the FSM IDLE -> RD_REQ -> RD_WAIT -> TX -> IDLE.
REQ-010 SHALL assert req_ready only in IDLE; on req_valid&&req_ready, it SHALL latch all descriptor fields and go to RD_REQ on the next cycle.
REQ-011 SHALL, in RD_REQ, assert bar0_mm_read with bar0_mm_address={addr[31:2],2'b00} and hold both stable until a cycle with !bar0_mm_waitrequest, then go to RD_WAIT.
REQ-012 SHALL, in RD_WAIT, capture bar0_mm_readdata on the first readdatavalid and go to TX; readdatavalid outside RD_WAIT/RD_REQ SHALL be ignored.
REQ-013 SHALL accept readdatavalid coincident with the accepting !waitrequest cycle (zero-latency slave) and go directly to TX.
REQ-014 SHALL, in TX, drive tx_st_valid=1, startofpacket=1, endofpacket=1 (single beat), error=0, and hold tx_st_data stable until tx_st_ready, then go to IDLE (ready latency 0).
REQ-015 SHALL form CplD DW0 as fmt=3'b010, type=5'b01010, TC=req_tc, attr=req_attr, length=10'd1, all other bits 0.
REQ-016 SHALL form DW1 as {COMPLETER_ID, status=3'b000, BCM=0, byte_count[11:0]}.
REQ-017 SHALL form DW2 as {req_requester_id, req_tag, 1'b0, lower_addr[6:0]}, where lower_addr={addr[6:2], offset of lowest set bit in first_be} (first_be=0 gives offset 00).
REQ-018 SHALL compute byte_count from first_be as: 1xx1->4; 01x1 or 1x10->3; 0011, 0110 or 1100->2; a single bit set or 0000->1.
REQ-019 SHALL, when addr[2]=1, place data in dword 3 with tx_st_empty=2'd2.
REQ-020 SHALL, when addr[2]=0, leave dword 3 zero, place data in dword 4, and drive tx_st_empty=2'd1.
REQ-021 SHALL drive all unused dwords to zero.
REQ-022 SHALL issue one outstanding request at a time, with no descriptor acceptance until TX completes.

Reset
REQ-023 SHALL, on reset_n low, immediately enter IDLE and clear all data/address registers.
REQ-024 SHALL hold req_ready=0, bar0_mm_read=0, bar0_mm_address=0, tx_st_valid=0, sop=0, eop=0, error=0, empty=0 and tx_st_data=0 while reset_n is low.
REQ-025 SHALL discard any in-flight request on reset mid-operation, with no completion emitted after reset release.

Configuration
REQ-026 SHALL support the macro FEJKON_PCIE_CPL_TIMEOUT_EN.
REQ-027 SHALL, when the macro is defined, count cycles in RD_REQ+RD_WAIT; on reaching TIMEOUT_CYCLES it SHALL go to TX and emit a 3DW Cpl: fmt=3'b000, type=01010, length=0, status=3'b100 (CA), tx_st_empty=2'd2, no data.
REQ-028 SHALL, when the macro is defined, ignore a late readdatavalid after a timeout.
REQ-029 SHALL, when the macro is undefined, omit the counter and wait in RD_WAIT indefinitely.

Structure
REQ-030 SHALL place in package fejkon_pcie_pkg: the fmt/type constants (FMT_3DW_DATA, FMT_3DW_NODATA, TYPE_CPL), the cpl status enum (SC, UR, CA), and the FSM state enum.
REQ-031 SHALL use one combinational sub-module, fejkon_pcie_cpl_bytecount (first_be -> byte_count, lower-address offset).

Verification
REQ-032 SHALL cover: addr=0x0000_0014, first_be=4'hF, tag=0x2A, rid=0x0100, readdata=0xDEADBEEF -> DW0=0x4A000001, DW1=0x00000004, DW2=0x01002A14, dword3=0xDEADBEEF, empty=2.
REQ-033 SHALL cover: addr=0x0000_0010, first_be=4'b0110 -> byte_count=2, lower_addr=0x11, dword3=0, data in dword4, empty=1.
REQ-034 SHALL cover: waitrequest held 5 cycles, then readdatavalid 3 cycles later -> read/address stable for all 6 cycles, exactly one completion.
REQ-035 SHALL cover: tx_st_ready low 10 cycles -> data and valid stable, req_ready=0 throughout, IDLE one cycle after the ready handshake.
REQ-036 SHALL cover: reset_n pulsed low in RD_WAIT, then readdatavalid arrives -> no tx_st_valid, and req_ready=1 after reset release.
REQ-037 SHALL cover, with FEJKON_PCIE_CPL_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: no readdatavalid -> Cpl DW0=0x0A000000, status CA, emitted 16 cycles after entering RD_REQ.
